mem_stage_lsu: RTL and testbench

Memory-access stage of the 64-bit pipelined LEGv8 CPU. It sits between the EX/MEM pipeline register and the MEM/WB register. It executes LDUR/STUR (doubleword) and LDURB/STURB (byte) against a variable-latency data memory through a req/ready handshake. It stalls upstream stages while an access is outstanding and passes non-memory instructions through with one cycle of latency.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_byte_lane.sv | 31 +++
 rtl/mem_stage_lsu.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the LEGv8 memory-access stage.
package lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_e;

  localparam int unsigned BYTE_LANES = 8;
  localparam int unsigned XLEN       = 64;

  // Lane enables: all lanes for a doubleword, one lane for a byte access.
  function automatic logic [BYTE_LANES-1:0] byte_enable(input logic       is_byte,
                                                        input logic [2:0] offset);
    logic [BYTE_LANES-1:0] one;
    one = {{(BYTE_LANES-1){1'b0}}, 1'b1};
    if (is_byte) begin
      return one << offset;
    end
    return '1;
  endfunction

  // Extract the addressed byte lane from a doubleword.
  function automatic logic [7:0] lane_select(input logic [XLEN-1:0] data,
                                             input logic [2:0]      offset);
    return data[8*offset +: 8];
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: store replication, byte enables, load lane extraction.
module lsu_byte_lane
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_xferByte,
  input  logic [2:0]            i_offset,
  input  logic [DATA_WIDTH-1:0] i_storeData,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic [BYTE_LANES-1:0] o_byteEn,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_loadData
);

  logic [7:0] w_lane;

  // Steer store data and load data according to access size and offset.
  always_comb begin
    o_byteEn = byte_enable(i_xferByte, i_offset);
    w_lane   = lane_select(i_rdata, i_offset);
    if (i_xferByte) begin
      o_wdata    = {BYTE_LANES{i_storeData[7:0]}};
      o_loadData = {{(DATA_WIDTH-8){1'b0}}, w_lane};
    end else begin
      o_wdata    = i_storeData;
      o_loadData = i_rdata;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// LEGv8 memory-access stage: issues LDUR/STUR/LDURB/STURB to a
// variable-latency data memory and drives the MEM/WB register bank.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_MemRead,
  input  logic                  in_MemWrite,
  input  logic                  in_xferByte,
  input  logic                  in_RegWrite,
  input  logic                  in_MemToReg,
  input  logic [4:0]            in_Rd,
  input  logic [DATA_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_storeData,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BYTE_LANES-1:0] mem_byteEn,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic                  wb_RegWrite,
  output logic [4:0]            wb_Rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  align_fault
);

  lsu_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_storeData;
  logic [4:0]            r_Rd;
  logic                  r_write;
  logic                  r_xferByte;
  logic                  r_RegWrite;
  logic                  r_MemToReg;

  logic                  r_wb_valid;
  logic                  r_wb_RegWrite;
  logic [4:0]            r_wb_Rd;
  logic [DATA_WIDTH-1:0] r_wb_data;
  logic                  r_fault;

  logic                  w_memop;
  logic                  w_fault;
  logic                  w_busy;
  logic [BYTE_LANES-1:0] w_byteEn;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_loadData;

  lsu_byte_lane #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_byte_lane (
    .i_xferByte (r_xferByte),
    .i_offset   (r_addr[2:0]),
    .i_storeData(r_storeData),
    .i_rdata    (mem_rdata),
    .o_byteEn   (w_byteEn),
    .o_wdata    (w_wdata),
    .o_loadData (w_loadData)
  );

  // Classify the instruction currently offered by EX/MEM.
  always_comb begin
    w_memop = in_valid & (in_MemRead | in_MemWrite);
    w_fault = w_memop & (((~in_xferByte) & (in_addr[2:0] != 3'b000)) |
                         (in_MemRead & in_MemWrite));
    w_busy  = (r_state == BUSY);
  end

  // Upstream hold: while accepting a legal memop, then until memory answers.
  // Reset forces it low so a held memop on the inputs cannot leak through.
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      if (w_busy) begin
        stall = ~mem_ready;
      end else begin
        stall = w_memop & ~w_fault;
      end
    end
  end

  // Memory port is driven only from the latched request while BUSY.
  always_comb begin
    mem_req    = w_busy;
    mem_we     = w_busy & r_write;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_byteEn = '0;
    if (w_busy) begin
      mem_addr   = {r_addr[DATA_WIDTH-1:3], 3'b000};
      mem_wdata  = w_wdata;
      mem_byteEn = w_byteEn;
    end
  end

  // FSM, request latches and MEM/WB register bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_storeData   <= '0;
      r_Rd          <= '0;
      r_write       <= 1'b0;
      r_xferByte    <= 1'b0;
      r_RegWrite    <= 1'b0;
      r_MemToReg    <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_RegWrite <= 1'b0;
      r_wb_Rd       <= '0;
      r_wb_data     <= '0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memop && !w_fault) begin
            r_addr        <= in_addr;
            r_storeData   <= in_storeData;
            r_Rd          <= in_Rd;
            r_write       <= in_MemWrite;
            r_xferByte    <= in_xferByte;
            r_RegWrite    <= in_RegWrite;
            r_MemToReg    <= in_MemToReg;
            r_wb_valid    <= 1'b0;
            r_wb_RegWrite <= 1'b0;
            r_state       <= BUSY;
          end else if (w_memop) begin
            r_wb_valid    <= 1'b1;
            r_wb_RegWrite <= 1'b0;
            r_wb_Rd       <= in_Rd;
            r_wb_data     <= '0;
            r_fault       <= 1'b1;
          end else if (in_valid) begin
            r_wb_valid    <= 1'b1;
            r_wb_RegWrite <= in_RegWrite;
            r_wb_Rd       <= in_Rd;
            r_wb_data     <= in_addr;
          end else begin
            r_wb_valid    <= 1'b0;
            r_wb_RegWrite <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            r_wb_valid    <= 1'b1;
            r_wb_RegWrite <= r_write ? 1'b0 : r_RegWrite;
            r_wb_Rd       <= r_Rd;
            r_wb_data     <= r_write ? '0 : (r_MemToReg ? w_loadData : r_addr);
            r_state       <= IDLE;
          end else begin
            r_wb_valid    <= 1'b0;
            r_wb_RegWrite <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Register outputs.
  always_comb begin
    wb_valid    = r_wb_valid;
    wb_RegWrite = r_wb_RegWrite;
    wb_Rd       = r_wb_Rd;
    wb_data     = r_wb_data;
    align_fault = r_fault;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_MemRead, in_MemWrite, in_xferByte;
  logic        in_RegWrite, in_MemToReg;
  logic [4:0]  in_Rd;
  logic [63:0] in_addr, in_storeData;
  logic        stall, mem_req, mem_we, mem_ready;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_byteEn;
  logic        wb_valid, wb_RegWrite, align_fault;
  logic [4:0]  wb_Rd;
  logic [63:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_lsu #(.DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_xferByte(in_xferByte), .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg),
    .in_Rd(in_Rd), .in_addr(in_addr), .in_storeData(in_storeData),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteEn(mem_byteEn), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_Rd(wb_Rd), .wb_data(wb_data), .align_fault(align_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_MemRead = 0; in_MemWrite = 0; in_xferByte = 0;
    in_RegWrite = 0; in_MemToReg = 0; in_Rd = '0; in_addr = '0; in_storeData = '0;
  endtask

  // Present a legal memop, hold it while stalled, answer after n BUSY cycles.
  // Returns right after the completing edge with the inputs idled.
  task automatic memop(input string tag, input logic wr, input logic bt,
                       input logic [4:0] rd, input logic [63:0] addr,
                       input logic [63:0] sd, input logic [63:0] rdata, input int n,
                       input logic [63:0] e_addr, input logic [7:0] e_be,
                       input logic [63:0] e_wdata);
    in_valid = 1; in_MemRead = ~wr; in_MemWrite = wr; in_xferByte = bt;
    in_RegWrite = ~wr; in_MemToReg = ~wr; in_Rd = rd; in_addr = addr; in_storeData = sd;
    #1;
    chk({tag, ".accept_stall"}, stall, 1);
    chk({tag, ".accept_noreq"}, mem_req, 0);
    tick();
    chk({tag, ".busy_wbv"}, wb_valid, 0);
    chk({tag, ".addr"}, mem_addr, e_addr);
    chk({tag, ".be"}, mem_byteEn, e_be);
    chk({tag, ".we"}, mem_we, wr);
    if (wr) chk({tag, ".wdata"}, mem_wdata, e_wdata);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        mem_ready = 1; mem_rdata = rdata;
      end
      #1;
      chk({tag, ".req"}, mem_req, 1);
      chk({tag, ".stall"}, stall, (i == n - 1) ? 0 : 1);
      tick();
    end
    mem_ready = 0; mem_rdata = '0;
    idle_in();
  endtask

  initial begin
    reset = 1; mem_ready = 0; mem_rdata = '0;
    idle_in();
    in_valid = 1; in_MemRead = 1; in_addr = 64'h40;
    tick(); tick();
    chk("rst.stall", stall, 0);
    chk("rst.req", mem_req, 0);
    chk("rst.wbv", wb_valid, 0);
    chk("rst.wbrw", wb_RegWrite, 0);
    chk("rst.wbdata", wb_data, 0);
    chk("rst.fault", align_fault, 0);
    idle_in();
    reset = 0;
    tick();

    // ADD passthrough
    in_valid = 1; in_RegWrite = 1; in_Rd = 5'd3; in_addr = 64'h1234;
    #1;
    chk("add.stall", stall, 0);
    tick();
    chk("add.wbv", wb_valid, 1);
    chk("add.rd", wb_Rd, 3);
    chk("add.data", wb_data, 64'h1234);
    chk("add.rw", wb_RegWrite, 1);
    chk("add.stall2", stall, 0);
    idle_in();
    tick();
    chk("add.bubble", wb_valid, 0);
    chk("add.bubble_rw", wb_RegWrite, 0);

    // mem_ready with no request outstanding is ignored
    mem_ready = 1;
    tick();
    chk("ign.wbv", wb_valid, 0);
    chk("ign.req", mem_req, 0);
    mem_ready = 0;

    // STUR / LDUR doubleword at 0x40, ready on 3rd BUSY cycle
    memop("stur", 1, 0, 5'd0, 64'h40, 64'hDEADBEEF_CAFEF00D, '0, 3,
          64'h40, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    chk("stur.wbv", wb_valid, 1);
    chk("stur.rw", wb_RegWrite, 0);
    chk("stur.reqdrop", mem_req, 0);
    memop("ldur", 0, 0, 5'd5, 64'h40, '0, 64'hDEADBEEF_CAFEF00D, 3,
          64'h40, 8'hFF, '0);
    chk("ldur.wbv", wb_valid, 1);
    chk("ldur.rw", wb_RegWrite, 1);
    chk("ldur.rd", wb_Rd, 5);
    chk("ldur.data", wb_data, 64'hDEADBEEF_CAFEF00D);
    tick();
    chk("ldur.once", wb_valid, 0);

    // Byte accesses
    memop("sturb", 1, 1, 5'd0, 64'h43, 64'h1234_5678_9ABC_DEA5, '0, 1,
          64'h40, 8'h08, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("sturb.rw", wb_RegWrite, 0);
    memop("ldurb", 0, 1, 5'd6, 64'h43, '0, 64'h1111_1111_A522_3344, 2,
          64'h40, 8'h08, '0);
    chk("ldurb.data", wb_data, 64'h0000_0000_0000_00A5);
    chk("ldurb.rd", wb_Rd, 6);
    memop("ldurb7", 0, 1, 5'd8, 64'h47, '0, 64'hF0AB_0000_0000_0000, 1,
          64'h40, 8'h80, '0);
    chk("ldurb7.zext", wb_data, 64'h0000_0000_0000_00F0);
    memop("sturb0", 1, 1, 5'd0, 64'h88, 64'h0000_0000_0000_003C, '0, 1,
          64'h88, 8'h01, 64'h3C3C_3C3C_3C3C_3C3C);
    tick();

    // Misaligned doubleword load
    in_valid = 1; in_MemRead = 1; in_RegWrite = 1; in_MemToReg = 1;
    in_Rd = 5'd7; in_addr = 64'h44;
    #1;
    chk("mis.stall", stall, 0);
    chk("mis.req", mem_req, 0);
    tick();
    chk("mis.wbv", wb_valid, 1);
    chk("mis.rw", wb_RegWrite, 0);
    chk("mis.fault", align_fault, 1);
    chk("mis.noreq", mem_req, 0);
    idle_in();
    tick();
    // Read and write together is illegal
    in_valid = 1; in_MemRead = 1; in_MemWrite = 1; in_RegWrite = 1; in_addr = 64'h50;
    #1;
    chk("rw.stall", stall, 0);
    tick();
    chk("rw.req", mem_req, 0);
    chk("rw.rw", wb_RegWrite, 0);
    chk("rw.wbv", wb_valid, 1);
    idle_in();
    memop("postfault", 0, 0, 5'd9, 64'h48, '0, 64'h0123_4567_89AB_CDEF, 2,
          64'h48, 8'hFF, '0);
    chk("postfault.data", wb_data, 64'h0123_4567_89AB_CDEF);
    chk("postfault.fault", align_fault, 1);
    tick();

    // Reset on the 2nd BUSY cycle
    in_valid = 1; in_MemRead = 1; in_RegWrite = 1; in_MemToReg = 1;
    in_Rd = 5'd10; in_addr = 64'h80;
    tick();
    chk("abort.busy1", mem_req, 1);
    tick();
    chk("abort.busy2", mem_req, 1);
    reset = 1;
    #1;
    chk("abort.req", mem_req, 0);
    chk("abort.stall", stall, 0);
    chk("abort.wbv", wb_valid, 0);
    chk("abort.fault", align_fault, 0);
    idle_in();
    tick();
    reset = 0;
    tick();
    chk("abort.noretry", mem_req, 0);
    in_valid = 1; in_RegWrite = 1; in_Rd = 5'd11; in_addr = 64'h55;
    tick();
    chk("post.wbv", wb_valid, 1);
    chk("post.rd", wb_Rd, 11);
    chk("post.data", wb_data, 64'h55);
    idle_in();

    // Back-to-back loads, ready in first BUSY cycle
    memop("b2b0", 0, 0, 5'd12, 64'h100, '0, 64'hAAAA_0000_0000_0001, 1,
          64'h100, 8'hFF, '0);
    chk("b2b0.wbv", wb_valid, 1);
    chk("b2b0.data", wb_data, 64'hAAAA_0000_0000_0001);
    memop("b2b1", 0, 0, 5'd13, 64'h108, '0, 64'hBBBB_0000_0000_0002, 1,
          64'h108, 8'hFF, '0);
    chk("b2b1.wbv", wb_valid, 1);
    chk("b2b1.rd", wb_Rd, 13);
    chk("b2b1.data", wb_data, 64'hBBBB_0000_0000_0002);
    tick();
    chk("b2b.end", wb_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
